seq_alu_core: RTL and testbench
===============================

// Module: seq_alu_core
// PURPOSE
//  Multi-cycle execute-stage ALU. Consumes the 4-bit ALU control code from the ALU control unit, plus both operands.
//  Performs arithmetic, logic, shift and DIFF operations with a start/done handshake.
//  Produces result and flags for writeback and branch logic.
//  Shifts and DIFF are iterative, so the pipeline stalls on busy.
// PARAMETERS
//  WIDTH    32  operand/result width
//  SHAMT_W  5   shift-count bits taken from op_b; must equal clog2(WIDTH)
// PORTS
//  clk       in   1        single clock; all state on rising edge
//  rst       in   1        synchronous, active-high reset
//  start     in   1        request; sampled only when not busy
//  alu_ctrl  in   4        operation code, latched on accepted start
//  op_a      in   WIDTH    operand A, latched on accepted start
//  op_b      in   WIDTH    operand B / shift count, latched on accepted start
//  result    out  WIDTH    registered result; holds until next completion
//  carry     out  1        ADD carry-out
//  zero      out  1        result==0
//  sign      out  1        result[WIDTH-1]
//  busy      out  1        high while in EXEC
//  done      out  1        1-cycle completion pulse
// BEHAVIOUR
//  Codes:
//   - 0000 ADD a+b; 0001 COMP ~b+1; 0010 DIFF; 0011 AND; 0100 XOR
//   - 0101 SHLL, 1101 SHLLV: logical left by b[SHAMT_W-1:0]
//   - 0110 SHRL, 1110 SHRLV: logical right
//   - 0111 SHRA, 1111 SHRAV: arithmetic right
//   - 1011 NOP; all other codes behave as NOP
//  Reset: state=IDLE, result=0, carry=zero=sign=busy=done=0. Reset mid-EXEC aborts; no done is produced.
//  FSM IDLE->(start)->EXEC or DONE; EXEC->DONE; DONE->IDLE. In DONE, start is also accepted (back-to-back).
//  Accept rule: start is accepted in IDLE or DONE. start while busy is ignored; operands are not relatched.
//  Single-cycle ops (ADD, COMP, AND, XOR, NOP, and shifts with count 0):
//   - start sampled at edge N; result/flags update and done=1 in cycle N+1
//  Shifts with count k>0: one bit per EXEC cycle, k EXEC cycles; done in cycle N+k+1.
//  DIFF: scans (a^b) from bit 0 upward, one bit per EXEC cycle, stopping at the first set bit i.
//   - result=i; i+1 EXEC cycles; done at N+i+2
//   - if a==b: WIDTH EXEC cycles, result=WIDTH
//  Flags:
//   - carry written by ADD only; cleared by all other non-NOP ops
//   - zero/sign recomputed from each new result
//   - NOP: result and flags unchanged, done still pulses at N+1
//  Arithmetic is modulo 2^WIDTH. COMP of 0 gives 0; COMP of 0x80000000 gives 0x80000000.
//  SHRA fills with original a[WIDTH-1] every step.
//  busy = (state==EXEC); done = (state==DONE); both are registered-state decodes.
// CONFIGURATION
//  FAST_SHIFT_EN defined:
//   - all shift codes use a single-cycle barrel shifter; done at N+1
//   - DIFF uses a priority encoder, done at N+1
//   - EXEC is used by no op
//  FAST_SHIFT_EN undefined: iterative timing as above; minimal area.
// TESTING
//  ADD a=0xFFFFFFFF b=1 -> done@N+1, result=0, carry=1, zero=1, sign=0.
//  SHRA a=0x80000000 b=4 (iterative) -> busy 4 cycles, done@N+5, result=0xF8000000, sign=1.
//  DIFF a=0x10 b=0x00 -> done@N+6, result=4; DIFF a=b=5 -> done@N+33, result=32.
//  start pulsed during busy SHLL b=3 -> ignored; later start on DONE cycle accepted; next done 1 cycle later.
//  rst asserted mid-SHRL b=10 -> next cycle busy=0, result=0, no done pulse.
//  FAST_SHIFT_EN build: SHLLV a=1 b=31 -> done@N+1, result=0x80000000, busy never 1.

Source files
------------

// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between the execute-stage issue logic and seq_alu_core.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             sign;
    logic             busy;
    logic             done;

    modport master (
        output start, alu_ctrl, op_a, op_b,
        input  result, carry, zero, sign, busy, done
    );

    modport slave (
        input  start, alu_ctrl, op_a, op_b,
        output result, carry, zero, sign, busy, done
    );
endinterface

// File: rtl/seq_alu_core.sv
// Multi-cycle execute-stage ALU with start/done handshake; shifts and DIFF iterate one bit per cycle.
// Define FAST_SHIFT_EN to use a barrel shifter and priority encoder so every op completes in one cycle.
module seq_alu_core #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    localparam int unsigned CNT_W = SHAMT_W + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [3:0] {
        K_ADD, K_COMP, K_DIFF, K_AND, K_XOR, K_SHLL, K_SHRL, K_SHRA, K_NOP
    } kind_t;

    state_t             state;
    kind_t              kind;
    kind_t              exec_kind;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               zero_q;
    logic               sign_q;
    logic [WIDTH-1:0]   work;
    logic [CNT_W-1:0]   cnt;
    logic               fill;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     sum;
    logic               accept;
    logic               go_exec;
    logic               finish;
    logic               wr;
    logic [WIDTH-1:0]   new_res;
    logic               new_carry;
    logic [WIDTH-1:0]   step;

    assign shamt = bus.op_b[SHAMT_W-1:0];
    assign sum   = {1'b0, bus.op_a} + {1'b0, bus.op_b};

    always_comb begin
        kind = K_NOP;
        case (bus.alu_ctrl)
            4'b0000:          kind = K_ADD;
            4'b0001:          kind = K_COMP;
            4'b0010:          kind = K_DIFF;
            4'b0011:          kind = K_AND;
            4'b0100:          kind = K_XOR;
            4'b0101, 4'b1101: kind = K_SHLL;
            4'b0110, 4'b1110: kind = K_SHRL;
            4'b0111, 4'b1111: kind = K_SHRA;
            default:          kind = K_NOP;
        endcase
    end

`ifdef FAST_SHIFT_EN
    logic [WIDTH-1:0] barrel;
    logic [WIDTH-1:0] penc;
    logic             found;

    always_comb begin
        case (kind)
            K_SHLL:  barrel = bus.op_a << shamt;
            K_SHRL:  barrel = bus.op_a >> shamt;
            K_SHRA:  barrel = $signed(bus.op_a) >>> shamt;
            default: barrel = bus.op_a;
        endcase
        penc  = WIDTH'(WIDTH);
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && (bus.op_a[i] ^ bus.op_b[i])) begin
                penc  = WIDTH'(i);
                found = 1'b1;
            end
        end
    end
`endif

    // DIFF walks the XOR pattern rightwards, so it shares the logical-right step.
    always_comb begin
        case (exec_kind)
            K_SHLL:  step = {work[WIDTH-2:0], 1'b0};
            K_SHRA:  step = {fill, work[WIDTH-1:1]};
            default: step = {1'b0, work[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        accept    = bus.start && (state != EXEC);
        go_exec   = 1'b0;
        finish    = 1'b0;
        wr        = 1'b0;
        new_res   = result_q;
        new_carry = 1'b0;
        if (state == EXEC) begin
            if (exec_kind == K_DIFF) begin
                if (work[0]) begin
                    wr      = 1'b1;
                    finish  = 1'b1;
                    new_res = WIDTH'(cnt);
                end else if (cnt == CNT_W'(WIDTH - 1)) begin
                    wr      = 1'b1;
                    finish  = 1'b1;
                    new_res = WIDTH'(WIDTH);
                end
            end else if (cnt == CNT_W'(1)) begin
                wr      = 1'b1;
                finish  = 1'b1;
                new_res = step;
            end
        end else if (accept) begin
            finish = 1'b1;
            wr     = 1'b1;
            case (kind)
                K_ADD: begin
                    new_res   = sum[WIDTH-1:0];
                    new_carry = sum[WIDTH];
                end
                K_COMP: new_res = ~bus.op_b + WIDTH'(1);
                K_AND:  new_res = bus.op_a & bus.op_b;
                K_XOR:  new_res = bus.op_a ^ bus.op_b;
`ifdef FAST_SHIFT_EN
                K_SHLL, K_SHRL, K_SHRA: new_res = barrel;
                K_DIFF:                 new_res = penc;
`else
                K_SHLL, K_SHRL, K_SHRA: begin
                    if (shamt == '0) begin
                        new_res = bus.op_a;
                    end else begin
                        finish  = 1'b0;
                        wr      = 1'b0;
                        go_exec = 1'b1;
                    end
                end
                K_DIFF: begin
                    finish  = 1'b0;
                    wr      = 1'b0;
                    go_exec = 1'b1;
                end
`endif
                default: wr = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            exec_kind <= K_NOP;
            result_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            sign_q    <= 1'b0;
            work      <= '0;
            cnt       <= '0;
            fill      <= 1'b0;
        end else begin
            if (wr) begin
                result_q <= new_res;
                carry_q  <= new_carry;
                zero_q   <= (new_res == '0);
                sign_q   <= new_res[WIDTH-1];
            end
            if (go_exec) begin
                state     <= EXEC;
                exec_kind <= kind;
                fill      <= bus.op_a[WIDTH-1];
                if (kind == K_DIFF) begin
                    work <= bus.op_a ^ bus.op_b;
                    cnt  <= '0;
                end else begin
                    work <= bus.op_a;
                    cnt  <= CNT_W'(shamt);
                end
            end else if (state == EXEC) begin
                if (finish) begin
                    state <= DONE;
                end else begin
                    work <= step;
                    cnt  <= (exec_kind == K_DIFF) ? cnt + 1'b1 : cnt - 1'b1;
                end
            end else if (finish) begin
                state <= DONE;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
    assign bus.sign   = sign_q;
    assign bus.busy   = (state == EXEC);
    assign bus.done   = (state == DONE);
endmodule

// File: tb/tb_seq_alu_core.sv
// Self-checking bench for seq_alu_core: transaction-level model compared every cycle plus directed literal checks.
module tb_seq_alu_core;
`ifdef FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu_core #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Spec-level view of one operation: result, carry, whether it is a NOP, and EXEC cycles spent.
    function automatic void model_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output bit cy, output bit nop, output int lat);
        int          k;
        logic [32:0] s;
        k   = int'(b[4:0]);
        r   = '0;
        cy  = 1'b0;
        nop = 1'b0;
        lat = 0;
        case (c)
            4'b0000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32]; end
            4'b0001: r = 32'd0 - b;
            4'b0010: begin
                r = 32'd32;
                lat = 32;
                for (int i = 31; i >= 0; i--) begin
                    if (a[i] != b[i]) begin r = 32'(i); lat = i + 1; end
                end
            end
            4'b0011: r = a & b;
            4'b0100: r = a ^ b;
            4'b0101, 4'b1101: begin r = a << k; lat = k; end
            4'b0110, 4'b1110: begin r = a >> k; lat = k; end
            4'b0111, 4'b1111: begin r = $signed(a) >>> k; lat = k; end
            default: nop = 1'b1;
        endcase
        if (FAST) lat = 0;
    endfunction

    logic [31:0] m_res, p_res;
    bit          m_carry, m_zero, m_sign, m_busy, m_done, p_carry, p_nop;
    int          m_rem, lat;

    task automatic commit();
        if (!p_nop) begin
            m_res   = p_res;
            m_carry = p_carry;
            m_zero  = (p_res == 32'd0);
            m_sign  = p_res[31];
        end
    endtask

    initial begin
        m_res = '0; m_carry = 0; m_zero = 0; m_sign = 0; m_busy = 0; m_done = 0; m_rem = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_res = '0; m_carry = 0; m_zero = 0; m_sign = 0; m_busy = 0; m_done = 0; m_rem = 0;
            end else begin
                m_done = 0;
                if (m_busy) begin
                    m_rem--;
                    if (m_rem == 0) begin m_busy = 0; m_done = 1; commit(); end
                end else if (bus.start) begin
                    model_op(bus.alu_ctrl, bus.op_a, bus.op_b, p_res, p_carry, p_nop, lat);
                    if (lat == 0) begin m_done = 1; commit(); end
                    else begin m_busy = 1; m_rem = lat; end
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("busy",   {31'd0, bus.busy},  {31'd0, m_busy});
            check("done",   {31'd0, bus.done},  {31'd0, m_done});
            check("result", bus.result,         m_res);
            check("carry",  {31'd0, bus.carry}, {31'd0, m_carry});
            check("zero",   {31'd0, bus.zero},  {31'd0, m_zero});
            check("sign",   {31'd0, bus.sign},  {31'd0, m_sign});
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 100);
    endtask

    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int n;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.alu_ctrl = c; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(n);
        check({name, "_lat"}, 32'(n), 32'(exp_lat));
        check({name, "_res"}, bus.result, exp_res);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.start = 1'b0; bus.alu_ctrl = 4'b0; bus.op_a = '0; bus.op_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_result", bus.result, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);

        run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 1, 32'd0);
        check("add_wrap_carry", {31'd0, bus.carry}, 32'd1);
        check("add_wrap_zero", {31'd0, bus.zero}, 32'd1);
        check("add_wrap_sign", {31'd0, bus.sign}, 32'd0);
        run_op("shra4", 4'b0111, 32'h8000_0000, 32'd4, FAST ? 1 : 5, 32'hF800_0000);
        check("shra4_sign", {31'd0, bus.sign}, 32'd1);
        check("shra4_carry", {31'd0, bus.carry}, 32'd0);
        run_op("diff_bit4", 4'b0010, 32'h10, 32'h0, FAST ? 1 : 6, 32'd4);
        run_op("diff_equal", 4'b0010, 32'd5, 32'd5, FAST ? 1 : 33, 32'd32);
        run_op("comp_zero", 4'b0001, 32'd0, 32'd0, 1, 32'd0);
        check("comp_zero_zero", {31'd0, bus.zero}, 32'd1);
        run_op("comp_min", 4'b0001, 32'd0, 32'h8000_0000, 1, 32'h8000_0000);
        run_op("comp_5", 4'b0001, 32'd0, 32'd5, 1, 32'hFFFF_FFFB);
        run_op("and", 4'b0011, 32'hF0F0_1234, 32'h0FF0_FFFF, 1, 32'h00F0_1234);
        run_op("xor", 4'b0100, 32'hA5A5_A5A5, 32'hFFFF_0000, 1, 32'h5A5A_A5A5);
        run_op("nop_1011", 4'b1011, 32'd1, 32'd1, 1, 32'h5A5A_A5A5);
        run_op("nop_1000", 4'b1000, 32'd0, 32'd0, 1, 32'h5A5A_A5A5);
        run_op("shll0", 4'b0101, 32'h1234_5678, 32'd0, 1, 32'h1234_5678);
        run_op("shllv31", 4'b1101, 32'd1, 32'd31, FAST ? 1 : 32, 32'h8000_0000);
        run_op("shrlv_mask", 4'b1110, 32'hF000_0000, 32'h25, FAST ? 1 : 6, 32'h0780_0000);
        run_op("shrl31", 4'b0110, 32'h8000_0000, 32'd31, FAST ? 1 : 32, 32'd1);
        run_op("shrav3", 4'b1111, 32'h7FFF_FFFF, 32'd3, FAST ? 1 : 4, 32'h0FFF_FFFF);

        // Start pulse during a busy shift must be dropped; a start on the DONE cycle is taken.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.alu_ctrl = 4'b0101; bus.op_a = 32'd1; bus.op_b = 32'd3;
        @(posedge clk); #1;
        bus.alu_ctrl = 4'b0000; bus.op_a = 32'd7; bus.op_b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(n);
        check("ignore_lat", 32'(n), FAST ? 32'd1 : 32'd3);
        check("ignore_res", bus.result, FAST ? 32'd14 : 32'd8);
        bus.start = 1'b1; bus.alu_ctrl = 4'b0000; bus.op_a = 32'd2; bus.op_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("b2b_done", {31'd0, bus.done}, 32'd1);
        check("b2b_res", bus.result, 32'd5);

        @(posedge clk); #1;
        bus.start = 1'b1; bus.alu_ctrl = 4'b0110; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, bus.done}, 32'd0);
        end

        run_op("add_after_rst", 4'b0000, 32'd3, 32'd4, 1, 32'd7);
        check("add_after_rst_carry", {31'd0, bus.carry}, 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
